// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter register and instruction-fetch sequencer.
// Presents the current PC and a constant step to the external PC adder and
// takes the adder sum back as the sequential next PC. It selects between the
// sum and jump/branch targets, and runs the imem request handshake with
// stall and halt control.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, a misaligned
// redirect target goes to TRAP_VECTOR and pulses misalign_err. When it is
// undefined, the low two bits of the target are cleared.
module pc_fetch_ctrl #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] PC_STEP      = XLEN'(4),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_step,
    input  logic [XLEN-1:0] pc_seq,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            stall,
    input  logic            halt_req,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    output logic            instr_valid,
    output logic            halted,
    output logic [31:0]     instr_count,
    output logic            misalign_err
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HALT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            advance;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] pc_nxt;

    assign pc_step     = PC_STEP;
    assign imem_addr   = pc_out;
    assign instr_valid = advance;

    // State register; reset forces BOOT immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, handshake outputs and the advance strobe.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        halted    = 1'b0;
        advance   = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                advance  = imem_ready & ~stall;
                if (advance && halt_req) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // Next-PC selection: jump beats branch, and branch beats the adder sum.
    always_comb begin
        redirect        = jump | branch_taken;
        redirect_target = jump ? jump_target : branch_target;
        pc_nxt          = pc_seq;
        if (redirect) begin
`ifdef MISALIGN_TRAP_EN
            pc_nxt = (redirect_target[1:0] != 2'b00) ? TRAP_VECTOR : redirect_target;
`else
            pc_nxt = {redirect_target[XLEN-1:2], 2'b00};
`endif
        end
    end

    // PC and retired-instruction counter; both move only on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out      <= RESET_VECTOR;
            instr_count <= '0;
        end else if (advance) begin
            pc_out      <= pc_nxt;
            instr_count <= instr_count + 32'd1;
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Misalignment flag is registered so that it lines up with the trap PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= advance & redirect & (redirect_target[1:0] != 2'b00);
        end
    end
`else
    logic unused_trap_vector;
    assign unused_trap_vector = ^TRAP_VECTOR;
    assign misalign_err       = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by
// randomized cycles, all checked against a behavioural model.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_out, pc_step, pc_seq;
    logic        branch_taken, jump, stall, halt_req, imem_ready;
    logic [31:0] branch_target, jump_target, imem_addr;
    logic        imem_req, instr_valid, halted, misalign_err;
    logic [31:0] instr_count;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Reference-model state
    logic [31:0] m_pc;
    logic [31:0] m_count;
    bit          m_boot;
    bit          m_halt;
    bit          m_err;

    always #5 clk = ~clk;

    // External PC adder
    assign pc_seq = pc_out + pc_step;

    pc_fetch_ctrl #(
        .XLEN(32),
        .RESET_VECTOR(32'h0000_0000),
        .PC_STEP(32'd4),
        .TRAP_VECTOR(32'h0000_0100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pc_out(pc_out), .pc_step(pc_step),
        .pc_seq(pc_seq), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .stall(stall), .halt_req(halt_req),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .instr_valid(instr_valid), .halted(halted), .instr_count(instr_count),
        .misalign_err(misalign_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_count = 32'h0;
        m_boot  = 1'b1;
        m_halt  = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".pc_out"}, pc_out, m_pc);
        chk({tag, ".instr_count"}, instr_count, m_count);
        chk({tag, ".halted"}, {31'b0, halted}, {31'b0, m_halt});
        chk({tag, ".misalign_err"}, {31'b0, misalign_err}, {31'b0, m_err});
    endtask

    // One clock cycle: drive the inputs, check the combinational outputs,
    // then check the registered state after the edge.
    task automatic step(input string tag, input bit rdy, input bit stl, input bit j,
                        input bit br, input bit hlt,
                        input logic [31:0] jt, input logic [31:0] bt);
        bit          adv;
        logic [31:0] tgt;
        imem_ready = rdy; stall = stl; jump = j; branch_taken = br;
        halt_req = hlt; jump_target = jt; branch_target = bt;
        #1;
        adv = !m_boot && !m_halt && rdy && !stl;
        chk({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, !m_boot && !m_halt});
        chk({tag, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, adv});
        chk({tag, ".imem_addr"}, imem_addr, m_pc);
        @(posedge clk);
        m_err = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (adv) begin
            if (j || br) begin
                tgt = j ? jt : bt;
`ifdef MISALIGN_TRAP_EN
                if (tgt % 4 != 0) begin
                    m_pc  = 32'h100;
                    m_err = 1'b1;
                end else begin
                    m_pc = tgt;
                end
`else
                m_pc = tgt - (tgt % 4);
`endif
            end else begin
                m_pc = m_pc + 4;
            end
            m_count = m_count + 1;
            if (hlt) m_halt = 1'b1;
        end
        #1;
        chk_regs(tag);
    endtask

    // Pulls reset low away from any clock edge and checks that it takes effect at once.
    task automatic async_reset(input string tag);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk({tag, ".imem_req"}, {31'b0, imem_req}, 32'h0);
        chk({tag, ".instr_valid"}, {31'b0, instr_valid}, 32'h0);
        chk({tag, ".pc_step"}, pc_step, 32'd4);
        chk_regs(tag);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        imem_ready = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        halt_req = 1'b0; jump_target = '0; branch_target = '0;
        model_reset();
        #12;
        chk_regs("reset");
        chk("reset.imem_req", {31'b0, imem_req}, 32'h0);
        chk("reset.pc_step", pc_step, 32'd4);
        rst_n = 1'b1;

        // Boot cycle, then sequential fetch
        step("boot", 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("seq", 1, 0, 0, 0, 0, 0, 0);

        // Jump and branch together: jump wins, then sequential from there
        step("jmp_pri", 1, 0, 1, 1, 0, 32'h200, 32'h80);
        step("after_jmp", 1, 0, 0, 0, 0, 0, 0);
        step("jmp20", 1, 0, 1, 0, 0, 32'h20, 0);

        // Not-ready and stalled cycles hold; redirect and halt are ignored
        for (int i = 0; i < 3; i++) step("not_ready", 0, i[0], 1, 1, 1, 32'h300, 32'h400);
        for (int i = 0; i < 2; i++) step("stalled", 1, 1, 1, 1, 1, 32'h300, 32'h400);
        step("clean", 1, 0, 0, 0, 0, 0, 0);

        // Misaligned branch target
        step("mis_br", 1, 0, 0, 1, 0, 0, 32'h42);
        step("mis_after", 1, 0, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0), 0,
                 $urandom, $urandom);
        end

        // Halt at 0x30, then nothing moves
        step("to30", 1, 0, 1, 0, 0, 32'h30, 0);
        step("halt", 1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) step("frozen", i[0], 0, 0, ~i[0], 1, 0, 32'h500);
        async_reset("rst_halt");

        // Reset while a request is outstanding
        step("boot2", 1, 0, 0, 0, 0, 0, 0);
        step("seq2", 1, 0, 0, 0, 0, 0, 0);
        step("seq2", 1, 0, 0, 0, 0, 0, 0);
        step("pend", 0, 0, 0, 0, 0, 0, 0);
        imem_ready = 1'b0;
        async_reset("rst_mid");
        step("boot3", 1, 0, 0, 0, 0, 0, 0);
        step("seq3", 1, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog so the bench always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
